// File: rtl/rv32i_types.sv
// Shared RV32 types: M-extension funct3 encoding and the multiply/divide FSM states.
package rv32i_types;

   typedef enum logic [2:0] {
      MUL    = 3'b000,
      MULH   = 3'b001,
      MULHSU = 3'b010,
      MULHU  = 3'b011,
      DIV    = 3'b100,
      DIVU   = 3'b101,
      REM    = 3'b110,
      REMU   = 3'b111
   } muldiv_funct3_t;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      CALC,
      FIX,
      DONE
   } muldiv_state_t;

   function automatic logic is_div(muldiv_funct3_t f);
      return f == DIV || f == DIVU || f == REM || f == REMU;
   endfunction

   function automatic logic div_uns(muldiv_funct3_t f);
      return f == DIVU || f == REMU;
   endfunction

   function automatic logic a_signed(muldiv_funct3_t f);
      return f == MULH || f == MULHSU || f == DIV || f == REM;
   endfunction

   function automatic logic b_signed(muldiv_funct3_t f);
      return f == MULH || f == DIV || f == REM;
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between a core pipeline and the multiply/divide unit.
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   import rv32i_types::*;

   logic                 start;
   muldiv_funct3_t       funct3;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 flush;
   logic                 ready;
   logic                 done;
   logic [WIDTH-1:0]     result;

   modport master (output start, funct3, a, b, flush, input ready, done, result);
   modport slave  (input start, funct3, a, b, flush, output ready, done, result);

endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide, one bit
// per cycle, with single-cycle bypass for divide corner cases and reuse of the last result.
module muldiv_unit
   import rv32i_types::*;
#(
   parameter int WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst,
   muldiv_unit_if.slave  io
);

   localparam int CW = $clog2(WIDTH + 1);

   muldiv_state_t    state;
   logic [CW-1:0]    cnt;
   logic             valid;
   logic             done_r;
   logic [WIDTH-1:0] result_r;

   logic [WIDTH-1:0] la, lb, mbr, st_hi, st_lo;
   muldiv_funct3_t   op, sf3;
   logic             neg_ab, neg_a;
   logic [2*WIDTH:0] acc, step, shl;
   logic [WIDTH:0]   sum, sub;

   logic             accept, hit, dz, ovf, bypass, sa, sb;
   logic [WIDTH-1:0] mag_a, mag_b, q_fix, r_fix, sel;
   logic [2*WIDTH-1:0] p_fix;

   assign io.ready  = (state == IDLE);
   assign io.done   = done_r;
   assign io.result = result_r;

   assign accept = (state == IDLE) && io.start && !io.flush;
   assign dz     = is_div(io.funct3) && (io.b == '0);
   assign ovf    = (io.funct3 == DIV || io.funct3 == REM) &&
                   (io.a == {1'b1, {(WIDTH-1){1'b0}}}) && (io.b == '1);
   // Low product half is signedness-independent, so mul can reuse any multiply.
   assign hit    = valid && (io.a == la) && (io.b == lb) &&
                   ((io.funct3 == sf3) ||
                    (io.funct3 == MUL && !is_div(sf3)) ||
                    (is_div(io.funct3) && is_div(sf3) && div_uns(io.funct3) == div_uns(sf3)));
   assign bypass = hit || dz || ovf;

   assign sa    = a_signed(op) && la[WIDTH-1];
   assign sb    = b_signed(op) && lb[WIDTH-1];
   assign mag_a = sa ? -la : la;
   assign mag_b = sb ? -lb : lb;

   assign p_fix = neg_ab ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
   assign q_fix = neg_ab ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign r_fix = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

   always_comb begin
      sel = st_hi;
      if (op == MUL || op == DIV || op == DIVU)
         sel = st_lo;
   end

   // One iteration: multiply adds then shifts right, divide shifts left then trial-subtracts.
   always_comb begin
      shl  = {acc[2*WIDTH-1:0], 1'b0};
      sub  = shl[2*WIDTH:WIDTH] - {1'b0, mbr};
      sum  = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mbr} : {(WIDTH+1){1'b0}});
      step = {1'b0, sum, acc[WIDTH-1:1]};
      if (is_div(op)) begin
         step = shl;
         if (shl[2*WIDTH:WIDTH] >= {1'b0, mbr})
            step = {sub, shl[WIDTH-1:1], 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         valid    <= 1'b0;
         done_r   <= 1'b0;
         result_r <= '0;
      end else begin
         done_r <= 1'b0;
         if (io.flush) begin
            state <= IDLE;
            cnt   <= '0;
            valid <= 1'b0;
         end else begin
            case (state)
               IDLE: if (accept) begin
                  if (bypass) begin
                     state <= DONE;
                     valid <= 1'b1;
                  end else begin
                     state <= PREP;
                  end
               end
               PREP: begin
                  state <= CALC;
                  cnt   <= CW'(WIDTH);
               end
               CALC: begin
                  cnt <= cnt - 1'b1;
                  if (cnt == CW'(1))
                     state <= FIX;
               end
               FIX: begin
                  state <= DONE;
                  valid <= 1'b1;
               end
               DONE: begin
                  state    <= IDLE;
                  done_r   <= 1'b1;
                  result_r <= sel;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Datapath and result store carry no reset; the valid flag guards their contents.
   always_ff @(posedge clk) begin
      case (state)
         IDLE: if (accept) begin
            la <= io.a;
            lb <= io.b;
            op <= io.funct3;
            if (!hit && dz) begin
               st_hi <= io.a;
               st_lo <= '1;
               sf3   <= io.funct3;
            end else if (!hit && ovf) begin
               st_hi <= '0;
               st_lo <= io.a;
               sf3   <= io.funct3;
            end
         end
         PREP: begin
            acc    <= {{(WIDTH+1){1'b0}}, mag_a};
            mbr    <= mag_b;
            neg_ab <= sa ^ sb;
            neg_a  <= sa;
         end
         CALC: acc <= step;
         FIX: begin
            if (is_div(op)) begin
               st_hi <= r_fix;
               st_lo <= q_fix;
            end else begin
               {st_hi, st_lo} <= p_fix;
            end
            sf3 <= op;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases, flush/reset aborts, random sweep.
module tb_muldiv_unit;
   import rv32i_types::*;

   localparam int W = 32;

   typedef struct {
      muldiv_funct3_t f;
      logic [31:0]    a;
      logic [31:0]    b;
      logic [31:0]    res;
      int             lat;
      int             st_edge;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];

   bit             m_valid = 1'b0;
   logic [31:0]    m_a = '0;
   logic [31:0]    m_b = '0;
   muldiv_funct3_t m_f = MUL;

   muldiv_unit_if #(.WIDTH(W)) bus ();

   muldiv_unit #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] golden(muldiv_funct3_t f, logic [31:0] x, logic [31:0] y);
      longint sx = longint'($signed(x));
      longint sy = longint'($signed(y));
      longint ux = longint'({32'b0, x});
      longint uy = longint'({32'b0, y});
      logic [63:0] p;
      case (f)
         MUL:    begin p = 64'(sx * sy); return p[31:0];  end
         MULH:   begin p = 64'(sx * sy); return p[63:32]; end
         MULHSU: begin p = 64'(sx * uy); return p[63:32]; end
         MULHU:  begin p = 64'(ux * uy); return p[63:32]; end
         DIV:    return (y == 0) ? 32'hFFFF_FFFF : 32'(sx / sy);
         REM:    return (y == 0) ? x : 32'(sx % sy);
         DIVU:   return (y == 0) ? 32'hFFFF_FFFF : 32'(ux / uy);
         default: return (y == 0) ? x : 32'(ux % uy);
      endcase
   endfunction

   function automatic bit reuse_hit(muldiv_funct3_t f, logic [31:0] x, logic [31:0] y);
      bit same;
      same = (f == m_f) ||
             (f == MUL && m_f inside {MUL, MULH, MULHSU, MULHU}) ||
             (f inside {DIV, REM} && m_f inside {DIV, REM}) ||
             (f inside {DIVU, REMU} && m_f inside {DIVU, REMU});
      return m_valid && x == m_a && y == m_b && same;
   endfunction

   function automatic bit div_bypass(muldiv_funct3_t f, logic [31:0] x, logic [31:0] y);
      return (f inside {DIV, DIVU, REM, REMU} && y == 0) ||
             (f inside {DIV, REM} && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %h required %h", nm, act, req);
      end
   endtask

   task automatic issue(input muldiv_funct3_t f, input logic [31:0] x, input logic [31:0] y,
                        input bit expect_done);
      int   n;
      bit   h;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (bus.ready !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (bus.ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout ready=%b required 1", bus.ready);
         return;
      end
      h = reuse_hit(f, x, y);
      bus.funct3 = f;
      bus.a      = x;
      bus.b      = y;
      bus.start  = 1'b1;
      if (expect_done) begin
         e.f = f; e.a = x; e.b = y;
         e.res     = golden(f, x, y);
         e.lat     = (h || div_bypass(f, x, y)) ? 1 : W + 3;
         e.st_edge = cyc + 1;
         q.push_back(e);
      end
      if (!h) begin
         m_valid = 1'b1; m_a = x; m_b = y; m_f = f;
      end
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() > 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout pending=%0d required 0", q.size());
         q.delete();
      end
   endtask

   function automatic logic [31:0] rnd_opnd();
      logic [31:0] corners [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
      if ($urandom_range(0, 9) < 2)
         return corners[$urandom_range(0, 4)];
      return 32'($urandom_range(0, 999)) - 32'd500;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_done result=%h required no done", bus.result);
            end else begin
               e = q.pop_front();
               checks += 2;
               if (bus.result !== e.res) begin
                  errors++;
                  $display("FAIL result %s a=%h b=%h got %h required %h",
                           e.f.name(), e.a, e.b, bus.result, e.res);
               end
               if (cyc - e.st_edge != e.lat) begin
                  errors++;
                  $display("FAIL latency %s a=%h b=%h got %0d required %0d",
                           e.f.name(), e.a, e.b, cyc - e.st_edge, e.lat);
               end
            end
         end
      end
   end

   initial begin
      logic [31:0]    saved, x, y;
      muldiv_funct3_t f;
      bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = MUL; bus.a = '0; bus.b = '0;
      repeat (2) @(negedge clk);
      check("reset_ready", 32'(bus.ready), 32'd1);
      check("reset_done", 32'(bus.done), 32'd0);
      check("reset_result", bus.result, 32'd0);
      rst = 1'b1;

      issue(MUL, -32'sd3, 32'd7, 1'b1);
      issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      issue(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      issue(REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      issue(DIVU, 32'd5, 32'd0, 1'b1);
      issue(REMU, 32'd5, 32'd0, 1'b1);
      issue(REM, -32'sd7, 32'd2, 1'b1);

      // A start while busy must be ignored.
      issue(MULH, 32'd1234, -32'sd77, 1'b1);
      repeat (5) @(negedge clk);
      bus.start = 1'b1; bus.funct3 = DIV; bus.a = 32'd9; bus.b = 32'd3;
      @(negedge clk);
      bus.start = 1'b0;
      drain();

      // Flush on the 10th CALC cycle.
      saved = bus.result;
      issue(MUL, 32'd100, 32'd200, 1'b0);
      repeat (10) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      m_valid = 1'b0;
      check("flush_ready", 32'(bus.ready), 32'd1);
      check("flush_result", bus.result, saved);
      repeat (45) @(negedge clk);
      check("flush_result_hold", bus.result, saved);

      // Flush and start together in IDLE: start dropped.
      bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = DIVU; bus.a = 32'd77; bus.b = 32'd5;
      @(negedge clk);
      bus.start = 1'b0; bus.flush = 1'b0;
      check("flush_start_ready", 32'(bus.ready), 32'd1);

      // Flush in IDLE clears the reuse store.
      issue(MUL, 32'd100, 32'd200, 1'b1);
      drain();
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      m_valid = 1'b0;
      issue(MUL, 32'd100, 32'd200, 1'b1);
      drain();

      // Asynchronous reset mid-CALC.
      issue(MUL, -32'sd3, 32'd7, 1'b1);
      drain();
      issue(DIVU, 32'd1000, 32'd7, 1'b0);
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("async_rst_ready", 32'(bus.ready), 32'd1);
      check("async_rst_result", bus.result, 32'd0);
      check("async_rst_done", 32'(bus.done), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      m_valid = 1'b0;
      issue(MUL, -32'sd3, 32'd7, 1'b1);
      drain();

      x = 32'd0;
      y = 32'd0;
      for (int i = 0; i < 160; i++) begin
         f = muldiv_funct3_t'($urandom_range(0, 7));
         if (i == 0 || $urandom_range(0, 3) != 0) begin
            x = rnd_opnd();
            y = rnd_opnd();
         end
         issue(f, x, y, 1'b1);
      end
      drain();
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL support any even value 8..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  one clock; reset is asynchronous and active-low (0 = reset).
REQ-004 start  input  1  request; sampled only when ready=1.
REQ-005 funct3  input  muldiv_funct3_t  operation: mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
REQ-006 a  input  WIDTH  operand rs1 / dividend.
REQ-007 b  input  WIDTH  operand rs2 / divisor.
REQ-008 flush  input  1  abort in-flight operation (pipeline kill).
REQ-009 ready  output  1  unit idle, accepts start this cycle.
REQ-010 done  output  1  single-cycle pulse, result valid.
REQ-011 result  output  WIDTH  selected result; held until next accepted start.

Function
REQ-012 States SHALL be IDLE, PREP, CALC, FIX, DONE; ready=1 only in IDLE.
REQ-013 IDLE + start=1 SHALL latch a, b, funct3 and go to PREP; start while ready=0 SHALL be ignored.
REQ-014 PREP SHALL take magnitudes of signed operands per funct3 (mulhsu: a signed, b unsigned), load counter = WIDTH, go to CALC.
REQ-015 CALC SHALL process one bit per cycle (radix-2 shift-add for multiply, restoring shift-subtract for divide), decrementing counter; at counter=1 go to FIX.
REQ-016 FIX SHALL apply sign correction (product negated if operand signs differ; quotient sign = sign(a) xor sign(b); remainder sign = sign(a)), store full 2*WIDTH product or quotient+remainder, go to DONE.
REQ-017 DONE SHALL assert done for exactly one cycle, drive result, return to IDLE.
REQ-018 Normal latency SHALL be WIDTH+3 cycles: start sampled at edge N -> done high in the cycle after edge N+WIDTH+3.
REQ-019 mul SHALL return product[WIDTH-1:0]; mulh/mulhsu/mulhu SHALL return product[2*WIDTH-1:WIDTH] for the respective signedness.
REQ-020 Divide by zero SHALL bypass CALC: quotient all ones, remainder = a; done after 1 cycle (IDLE->DONE).
REQ-021 Signed overflow (a = most-negative, b = all ones, div/rem) SHALL bypass CALC: quotient = a, remainder = 0; 1-cycle latency.
REQ-022 Reuse: unit SHALL keep last a, b, op class and stored results with a valid flag; an accepted start hitting the store SHALL go IDLE->DONE (1-cycle latency).
REQ-023 Reuse hit conditions: identical a, b and (same funct3; or mul after any multiply, low half being signedness-independent; or div/rem pair of matching signedness).
REQ-024 flush SHALL return the unit to IDLE on the next edge from any state, suppress done, and clear the reuse valid flag; flush in IDLE SHALL be harmless; flush and start in the same IDLE cycle: flush wins, start dropped.
REQ-025 An aborted operation SHALL never update result.

Reset
REQ-026 rst=0 SHALL immediately force state=IDLE, ready=1, done=0, result=0, counter=0, reuse valid=0, independent of clk.
REQ-027 Reset mid-CALC SHALL discard the operation; first start after release SHALL run full latency.

Structure
REQ-028 muldiv_funct3_t SHALL come from rv32i_types; the state enum muldiv_state_t SHALL be added to rv32i_types.
REQ-029 Single module; no sub-module; shared 2*WIDTH+1 datapath register for multiply and divide.

Verification (WIDTH=32)
REQ-030 mul a=-3 b=7 -> result 0xFFFFFFEB, done exactly 35 cycles after start edge, one-cycle pulse.
REQ-031 mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE (35 cycles); immediately mul same operands -> 0x00000001 in 1 cycle.
REQ-032 div 0x80000000 / 0xFFFFFFFF -> 0x80000000; rem same -> 0x00000000; both 1 cycle.
REQ-033 divu 5/0 -> 0xFFFFFFFF, remu 5/0 -> 0x00000005, 1 cycle each; rem -7/2 -> 0xFFFFFFFF.
REQ-034 flush at 10th CALC cycle -> no done, ready=1 next cycle, result unchanged; rst=0 mid-CALC between edges -> ready=1 and result=0 before next edge.
REQ-035 Random sweep, all 8 ops, operands in [-500,499] plus corner values (0, 1, -1, min, max) -> result matches golden model.
